// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: op codes, FSM states
// and the chunk-count helper.
package addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(int width, int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk_addr.sv
// Combinational W-bit adder slice with carry in/out; one slice is reused every
// cycle by addsub_seq.
module chunk_addr #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub with carry: processes CHUNK bits per clock through a single
// chunk_addr slice, valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for a request, inReady = 1
// CALC  | one chunk per edge, sum holds partial result
// DONE  | result and flags held until outReady
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       op,
  input  logic             cIn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             outC,
  output logic             ovFL,
  output logic             zero,
  output logic             neg
);

  localparam int NCH = chunk_count(WIDTH, CHUNK);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c;
  logic             r_ov;
  logic             r_zero;
  logic             r_neg;

  logic             w_accept;
  logic             w_last;
  logic             w_sub;
  logic             w_c0;
  logic             w_ov;
  logic             w_cout;
  int               w_off;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s_chunk;
  logic [WIDTH-1:0] w_sum_nxt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (inValid) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (outReady) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inReady  = (r_state == IDLE);
    outValid = (r_state == DONE);
  end

  assign w_accept = inValid && inReady;
  assign w_last   = (r_cnt == LAST);
  assign w_sub    = (op == OP_SUB) || (op == OP_SBC);

  always_comb begin
    case (op)
      OP_ADD:  w_c0 = 1'b0;
      OP_SUB:  w_c0 = 1'b1;
      default: w_c0 = cIn;
    endcase
  end

  assign w_off     = int'(r_cnt) * CHUNK;
  assign w_a_chunk = r_a[w_off +: CHUNK];
  assign w_b_chunk = r_bx[w_off +: CHUNK];

  chunk_addr #(.W(CHUNK)) u_chunk (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_s_chunk),
    .o_cout (w_cout)
  );

  always_comb begin
    w_sum_nxt = r_sum;
    w_sum_nxt[w_off +: CHUNK] = w_s_chunk;
  end

  // Flags are taken from the merged result so they are valid on the last-chunk edge.
  assign w_ov = (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (w_sum_nxt[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_bx    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_ov    <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= A;
      r_bx    <= w_sub ? ~B : B;
      r_carry <= w_c0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_ov    <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (r_state == CALC) begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_cout;
      if (w_last) begin
        r_cnt  <= '0;
        r_c    <= w_cout;
        r_ov   <= w_ov;
        r_zero <= (w_sum_nxt == '0);
        r_neg  <= w_sum_nxt[WIDTH-1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign outC = r_c;
  assign ovFL = r_ov;
  assign zero = r_zero;
  assign neg  = r_neg;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: a 32/8 instance and an 8/8 single-cycle
// instance, checked against an arithmetic reference model plus literal vectors.
module tb_addsub_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ov;
    logic        z;
    logic        n;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  op;
  logic        cin;
  logic [31:0] a, b;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] sum32;
  logic        c32, f32, z32, n32;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  sum8;
  logic        c8, f8, z8, n8;

  int n_assert = 0;
  int n_fail   = 0;

  res_t q32[$];
  res_t q8[$];

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rstN(rst_n), .inValid(iv32), .inReady(ir32), .op(op), .cIn(cin),
    .A(a), .B(b), .outValid(ov32), .outReady(or32), .sum(sum32), .outC(c32),
    .ovFL(f32), .zero(z32), .neg(n32)
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rstN(rst_n), .inValid(iv8), .inReady(ir8), .op(op), .cIn(cin),
    .A(a[7:0]), .B(b[7:0]), .outValid(ov8), .outReady(or8), .sum(sum8), .outC(c8),
    .ovFL(f8), .zero(z8), .neg(n8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t lit(input logic [31:0] s, input logic c, input logic ov,
                               input logic z, input logic n);
    res_t r;
    r.sum = s; r.c = c; r.ov = ov; r.z = z; r.n = n;
    return r;
  endfunction

  // Reference: whole-word unsigned sum for carry, signed range test for overflow.
  function automatic res_t model(input int w, input logic [1:0] o, input logic ci,
                                 input logic [31:0] av, input logic [31:0] bv);
    res_t r;
    longint unsigned m, ua, ub, cz, full;
    longint sa, sb, s, half;
    m  = (64'd1 << w) - 64'd1;
    ua = 64'(av) & m;
    ub = 64'(bv) & m;
    if (o == 2'd1 || o == 2'd3) ub = ~ub & m;
    cz = (o == 2'd0) ? 64'd0 : (o == 2'd1) ? 64'd1 : 64'(ci);
    full = ua + ub + cz;
    half = longint'(64'd1 << (w - 1));
    sa = longint'(ua);
    sb = longint'(ub);
    if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - 2 * half;
    if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - 2 * half;
    s = sa + sb + longint'(cz);
    r.sum = 32'(full & m);
    r.c   = ((full >> w) & 64'd1) != 0;
    r.ov  = (s >= half) || (s < -half);
    r.z   = (full & m) == 0;
    r.n   = ((full >> (w - 1)) & 64'd1) != 0;
    return r;
  endfunction

  function automatic logic rdy(input bit s);
    return s ? ir8 : ir32;
  endfunction

  function automatic logic vld(input bit s);
    return s ? ov8 : ov32;
  endfunction

  function automatic res_t obs(input bit s);
    return s ? lit({24'h0, sum8}, c8, f8, z8, n8) : lit(sum32, c32, f32, z32, n32);
  endfunction

  // Output checker: every cycle a result is presented it must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (q32.size() == 0) chk("unexpected_valid32", 64'(ov32), 64'd0);
      else chk("result32", 64'(obs(1'b0)), 64'(q32[0]));
    end
    if (rst_n && ov8) begin
      if (q8.size() == 0) chk("unexpected_valid8", 64'(ov8), 64'd0);
      else chk("result8", 64'(obs(1'b1)), 64'(q8[0]));
    end
  end

  always @(posedge clk) begin
    if (ov32 && or32 && q32.size() > 0) void'(q32.pop_front());
    if (ov8 && or8 && q8.size() > 0) void'(q8.pop_front());
  end

  task automatic run_op(input bit sel, input logic [1:0] o, input logic ci,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int hold, input bit poke, output res_t got);
    int  edges;
    bit  seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin seen = 1; break; end
    end
    chk("in_ready_timeout", 64'(seen), 64'd1);
    op = o; cin = ci; a = av; b = bv;
    if (sel) begin iv8 = 1'b1; q8.push_back(model(8, o, ci, av, bv)); end
    else     begin iv32 = 1'b1; q32.push_back(model(32, o, ci, av, bv)); end
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv32 = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); cin = 1'($urandom);
    edges = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (vld(sel)) begin seen = 1; break; end
    end
    chk("out_valid_timeout", 64'(seen), 64'd1);
    chk("latency", 64'(edges), sel ? 64'd1 : 64'd4);
    got = obs(sel);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin iv8 = 1'b0; iv32 = 1'b0; end
      chk("hold_in_ready", 64'(rdy(sel)), 64'd0);
      chk("hold_out_valid", 64'(vld(sel)), 64'd1);
      if (poke && i == 0) begin
        a = 32'h1; b = 32'h1; op = 2'd0;
        if (sel) iv8 = 1'b1; else iv32 = 1'b1;
      end
      @(negedge clk);
    end
    iv8 = 1'b0; iv32 = 1'b0;
    if (sel) or8 = 1'b1; else or32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0; or32 = 1'b0;
    chk("post_hs_out_valid", 64'(vld(sel)), 64'd0);
    chk("post_hs_in_ready", 64'(rdy(sel)), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t got;
    rst_n = 1'b0;
    iv32 = 1'b0; or32 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    op = 2'd0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out32", 64'({ov32, ir32, sum32, c32, f32, z32, n32}), 64'({1'b0, 1'b1, 36'h0}));
    chk("rst_out8", 64'({ov8, ir8, sum8, c8, f8, z8, n8}), 64'({1'b0, 1'b1, 12'h0}));
    rst_n = 1'b1;

    run_op(1'b0, 2'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3, 1'b1, got);
    chk("t1_add_ovf", 64'(got), 64'(lit(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1)));
    repeat (3) begin
      @(negedge clk);
      chk("ignored_req_idle", 64'({ir32, ov32}), 64'b10);
    end

    run_op(1'b0, 2'd1, 1'b1, 32'h0000_0005, 32'h0000_0005, 0, 1'b0, got);
    chk("t2_sub_zero", 64'(got), 64'(lit(32'h0, 1'b1, 1'b0, 1'b1, 1'b0)));
    run_op(1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0000_0001, 1, 1'b0, got);
    chk("t3_sub_borrow", 64'(got), 64'(lit(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1)));
    run_op(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0000_0000, 0, 1'b0, got);
    chk("t3_sbc_ovf", 64'(got), 64'(lit(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0)));
    run_op(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, got);
    chk("t4_adc_ripple", 64'(got), 64'(lit(32'h0, 1'b1, 1'b0, 1'b1, 1'b0)));
    run_op(1'b0, 2'd0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, got);
    chk("add_mixed", 64'(got), 64'(lit(32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1)));
    run_op(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0000_0003, 0, 1'b0, got);
    chk("sbc_borrow_in", 64'(got), 64'(lit(32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b0)));
    for (int i = 0; i < 6; i++)
      run_op(1'b0, 2'(i % 4), 1'($urandom), $urandom, $urandom, i % 2, 1'b0, got);

    // Abort mid-CALC: partial sum visible, then reset clears everything.
    @(negedge clk);
    op = 2'd0; cin = 1'b0; a = 32'h1122_3344; b = 32'h0101_0101; iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("partial_sum", 64'(sum32), 64'h3445);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({ov32, sum32, c32, f32, z32, n32}), 64'd0);
    chk("abort_in_ready", 64'(ir32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("after_abort", 64'({ir32, ov32}), 64'b10);
    end

    run_op(1'b1, 2'd0, 1'b0, 32'h7F, 32'h01, 0, 1'b0, got);
    chk("w8_add_ovf", 64'(got), 64'(lit(32'h80, 1'b0, 1'b1, 1'b0, 1'b1)));
    run_op(1'b1, 2'd1, 1'b0, 32'h80, 32'h01, 2, 1'b1, got);
    chk("w8_sub_ovf", 64'(got), 64'(lit(32'h7F, 1'b1, 1'b1, 1'b0, 1'b0)));
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 2'(i), 1'($urandom), $urandom, $urandom, 0, 1'b0, got);

    repeat (3) @(negedge clk);
    chk("queues_drained", 64'(q32.size() + q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Parametrised multi-cycle adder/subtractor. It is the successor to the 8-bit ripple add/sub with overflow flag.
- Operand width is generic. The sum is computed CHUNK bits per clock, which keeps the carry chain short at wide WIDTH.
- Adds add-with-carry and subtract-with-borrow modes, plus zero and negative flags.
- Uses valid/ready handshakes on both sides and sits between the register file and the ALU result bus.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; CHUNK == WIDTH gives a single-cycle compute.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstN  in  1  reset, asynchronous assert, active-low.
- inValid  in  1  request valid.
- inReady  out  1  block can accept a request.
- op  in  2  operation: 0 ADD, 1 SUB, 2 ADC, 3 SBC.
- cIn  in  1  carry in; used by ADC/SBC only.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- outC  out  1  carry out of the MSB; for SUB/SBC, 1 means no borrow.
- ovFL  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

Behaviour:
- Reset (rstN low, asynchronous):
  - State goes to IDLE; chunk counter to 0.
  - sum, outC, ovFL, zero, neg, outValid = 0; inReady = 1 once in IDLE.
- Effective operands, latched at accept:
  - Bx = B for ADD/ADC; Bx = ~B for SUB/SBC.
  - Initial carry c0: ADD = 0, SUB = 1, ADC = cIn, SBC = cIn.
- IDLE state:
  - inReady = 1, outValid = 0.
  - On inValid && inReady at an edge: latch A, Bx and c0; clear the result register; counter = 0; go to CALC.
- CALC state:
  - inReady = 0.
  - Each edge adds chunk k = counter: A[k*CHUNK +: CHUNK] + Bx[k*CHUNK +: CHUNK] + carry.
  - The chunk result is written into sum; the carry is registered for the next chunk; counter increments.
  - On the edge processing the last chunk (k = WIDTH/CHUNK - 1):
    - outC = final carry.
    - ovFL = (A[MSB] == Bx[MSB]) && (sum[MSB] != A[MSB]).
    - zero and neg are computed from the full result.
    - Go to DONE.
- Latency: outValid asserts WIDTH/CHUNK edges after the accept edge (4 for the defaults, 1 for CHUNK == WIDTH).
- DONE state:
  - outValid = 1, inReady = 0.
  - sum and all flags are held stable while outReady = 0.
  - On outValid && outReady: go to IDLE; outValid drops on the next cycle.
- No same-cycle re-accept. Throughput is one operation per WIDTH/CHUNK + 2 cycles.
- sum holds partial results during CALC. Consumers qualify sum with outValid only.
- Requests presented while inReady = 0 are ignored, not queued.
- Changes on A, B, op or cIn after accept have no effect.
- Reset mid-CALC or mid-DONE aborts the operation. No result is emitted and all outputs return to their reset values.
- Width rule: internal chunk sum is CHUNK+1 bits; the top bit is the carry.

Decomposition:
- Package addsub_pkg:
  - op encoding constants OP_ADD, OP_SUB, OP_ADC, OP_SBC.
  - State enum IDLE / CALC / DONE.
  - Function computing the chunk count WIDTH/CHUNK.
- Sub-module chunk_addr: combinational CHUNK-bit adder with cIn and cOut, instantiated once inside addsub_seq.
- Elaboration check: WIDTH % CHUNK == 0, otherwise error.

Test Plan:
1. ADD, A=0x7FFFFFFF, B=0x00000001 -> 4 edges after accept: sum=0x80000000, ovFL=1, outC=0, neg=1, zero=0.
2. SUB, A=0x00000005, B=0x00000005 -> sum=0x00000000, zero=1, outC=1, ovFL=0, neg=0.
3. SUB, A=0x00000000, B=0x00000001 -> sum=0xFFFFFFFF, outC=0 (borrow), neg=1, ovFL=0. SBC, A=0x80000000, B=0x00000000, cIn=0 -> sum=0x7FFFFFFF, ovFL=1, outC=1.
4. ADC, A=0xFFFFFFFF, B=0x00000000, cIn=1 -> carry ripples through all 4 chunks: sum=0x00000000, outC=1, zero=1, ovFL=0.
5. Backpressure and ignored request:
   - Result ready, outReady=0 for 3 cycles -> sum and flags stable, outValid=1, inReady=0.
   - A second inValid pulse in this window is ignored.
   - outReady=1 -> IDLE, inReady=1 the next cycle.
6. Reset and single-cycle instance:
   - rstN pulsed low during CALC chunk 2 -> outputs are 0 immediately; after release inReady=1 and no outValid appears.
   - Instance WIDTH=8, CHUNK=8: ADD 0x7F+0x01 -> outValid 1 edge after accept, sum=0x80, ovFL=1.
